// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor controller: computes a - b - bin one bit per clock, LSB first.
// Optional signed overflow output is enabled by defining SERIAL_SUB_OVF_EN.
module serial_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-2:0] res_sh;
    logic             brw;
    logic [CW-1:0]    cnt;
    logic             d_bit;
    logic             b_bit;

    function automatic logic sub_diff(input logic x, input logic y, input logic z);
        return x ^ y ^ z;
    endfunction

    function automatic logic sub_borrow(input logic x, input logic y, input logic z);
        return (~x & y) | (~x & z) | (y & z);
    endfunction

    always_comb begin
        d_bit = sub_diff(a_sh[0], b_sh[0], brw);
        b_bit = sub_borrow(a_sh[0], b_sh[0], brw);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            diff   <= '0;
            bout   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf    <= 1'b0;
`endif
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            brw    <= 1'b0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh   <= a;
                        b_sh   <= b;
                        brw    <= bin;
                        res_sh <= '0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    // Result bits enter at the top so the LSB ends up at bit 0.
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    res_sh <= (res_sh >> 1) | ((WIDTH-1)'(d_bit) << (WIDTH - 2));
                    brw    <= b_bit;
                    cnt    <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        // brw is the borrow into the MSB stage at this point.
                        diff  <= {d_bit, res_sh};
                        bout  <= b_bit;
`ifdef SERIAL_SUB_OVF_EN
                        ovf   <= brw ^ b_bit;
`endif
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Scoreboard bench for serial_sub_ctrl (WIDTH=8); ovf is checked when SERIAL_SUB_OVF_EN is defined.
module tb_serial_sub_ctrl;

    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];

    serial_sub_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
`ifdef SERIAL_SUB_OVF_EN
        .ovf   (ovf),
`endif
        .bout  (bout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Monitor: pops one expected result per done pulse.
    always @(negedge clk) begin
        if (!rst) begin
            if (done && busy) check("busy_done_overlap", {busy, done}, 32'h2);
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'(done), 32'h0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("diff", 32'(diff), 32'(e.d));
                    check("bout", 32'(bout), 32'(e.bo));
`ifdef SERIAL_SUB_OVF_EN
                    check("ovf", 32'(ovf), 32'(e.ov));
`endif
                end
            end
        end
    end

    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi,
                          input logic [W-1:0] ed, input logic eb, input logic eo);
        @(negedge clk);
        a = av; b = bv; bin = bi; start = 1'b1;
        sb.push_back('{d: ed, bo: eb, ov: eo});
        @(posedge clk);
        #1 start = 1'b0;
        a = ~av; b = ~bv; bin = ~bi;
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            check("busy_run", {30'd0, busy, done}, 32'h2);
        end
        @(negedge clk);
        check("done_pulse", {30'd0, busy, done}, 32'h1);
        @(negedge clk);
        check("done_end", {30'd0, busy, done}, 32'h0);
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!done) check(name, 32'(done), 32'h1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        #1;
        check("reset_outputs", {busy, done, bout, diff}, 32'h0);
        #20;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("idle_after_reset", {busy, done}, 32'h0);

        run_op(8'h5A, 8'h23, 1'b0, 8'h37, 1'b0, 1'b0);
        run_op(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
        run_op(8'h10, 8'h10, 1'b1, 8'hFF, 1'b1, 1'b0);
        run_op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
        run_op(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);
        run_op(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);

        // Abort mid-run: no result is pushed, so any done would be flagged.
        @(negedge clk);
        a = 8'h5A; b = 8'h23; bin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_outputs", {busy, done, bout, diff}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("abort_no_done", {busy, done}, 32'h0);
        run_op(8'h09, 8'h04, 1'b0, 8'h05, 1'b0, 1'b0);

        // Back-to-back with start held and operands changing during RUN.
        @(negedge clk);
        a = 8'hC3; b = 8'h41; bin = 1'b0; start = 1'b1;
        sb.push_back('{d: 8'h82, bo: 1'b0, ov: 1'b0});
        @(posedge clk);
        #1 a = 8'h30; b = 8'h50;
        sb.push_back('{d: 8'hE0, bo: 1'b1, ov: 1'b0});
        @(negedge clk);
        wait_done("timeout_b2b_first");
        @(negedge clk);
        check("b2b_idle_gap", {busy, done}, 32'h0);
        @(negedge clk);
        check("b2b_accept", {busy, done}, 32'h2);
        start = 1'b0;
        a = 8'hFF; b = 8'h00;
        wait_done("timeout_b2b_second");
        repeat (3) @(negedge clk);
        check("no_restart", {busy, done}, 32'h0);
        check("scoreboard_empty", 32'(sb.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule

// File: doc/serial_sub_ctrl.md
SERIAL_SUB_CTRL -- requirements
Module: serial_sub_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits; legal range 2..32.
REQ-002 Port: clk  input  1  system clock; all state changes on its rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: start  input  1  request to begin one subtraction; sampled only in IDLE.
REQ-005 Port: a  input  WIDTH  minuend; captured when start is accepted.
REQ-006 Port: b  input  WIDTH  subtrahend; captured when start is accepted.
REQ-007 Port: bin  input  1  initial borrow-in; captured when start is accepted.
REQ-008 Port: busy  output  1  high while an operation is in RUN.
REQ-009 Port: done  output  1  one-cycle pulse marking a valid result.
REQ-010 Port: diff  output  WIDTH  registered result of a - b - bin, modulo 2^WIDTH.
REQ-011 Port: bout  output  1  registered final borrow out of the MSB stage.
REQ-012 Port: ovf  output  1  registered signed overflow flag; present only when SERIAL_SUB_OVF_EN is defined.

Function
REQ-013 The block SHALL sequence one 1-bit full subtractor over WIDTH cycles, LSB first. Per bit: D = x^y^z and B = (~x&y)|(~x&z)|(y&z), where x = minuend bit, y = subtrahend bit, z = borrow register.
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-015 IDLE with start=1 at edge 0:
- capture a, b and bin into internal shift/borrow registers;
- clear the bit counter;
- go to RUN.
IDLE with start=0: remain in IDLE.
REQ-016 RUN, edges 1..WIDTH, one bit per edge:
- shift D into the internal result register MSB-side;
- shift both operands right;
- load the borrow register with B;
- increment the counter.
REQ-017 At edge WIDTH the FSM SHALL enter DONE and simultaneously load diff, bout (and ovf) from the completed internal state.
REQ-018 DONE SHALL last exactly one cycle, with done=1, then return to IDLE unconditionally.
REQ-019 Latency: done is high during the cycle following edge WIDTH; with WIDTH=8, done is high between edges 8 and 9.
REQ-020 busy SHALL equal 1 exactly while in RUN; done SHALL equal 1 exactly while in DONE; both are never high together.
REQ-021 start in RUN or DONE SHALL be ignored, with no capture and no restart; start held high continuously yields back-to-back operations, with one idle cycle between done and the next accept.
REQ-022 diff, bout and ovf SHALL hold their last loaded values from DONE until the next DONE; changes on a, b and bin after acceptance have no effect.
REQ-023 The counter SHALL be $clog2(WIDTH+1) bits wide and never wrap within an operation.

Reset
REQ-024 rst=1 SHALL immediately force: state IDLE; busy, done, diff, bout, ovf, counter, borrow and shift registers all 0.
REQ-025 Reset asserted mid-RUN SHALL abort the operation with no done pulse. The first start after rst deasserts SHALL run normally.

Configuration
REQ-026 Macro SERIAL_SUB_OVF_EN:
- Defined: the ovf port exists, and at edge WIDTH it loads (borrow into the MSB stage) XOR (borrow out of the MSB stage), i.e. two's-complement overflow of a - b - bin.
- Undefined: the ovf port and its logic are absent; all other behaviour is identical.

Verification
REQ-027 WIDTH=8, a=0x5A, b=0x23, bin=0, start pulsed at edge 0 -> busy high edges 1..8, done high only between edges 8 and 9, diff=0x37, bout=0.
REQ-028 a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1; then a=0x10, b=0x10, bin=1 -> diff=0xFF, bout=1.
REQ-029 With SERIAL_SUB_OVF_EN defined: a=0x80, b=0x01 -> diff=0x7F, bout=0, ovf=1; a=0x7F, b=0xFF -> diff=0x80, bout=1, ovf=1; a=0x05, b=0x03 -> ovf=0.
REQ-030 rst asserted asynchronously after edge 4 of an operation -> all outputs 0 immediately, no done; after release, a=0x09, b=0x04 -> diff=0x05 after 8 RUN cycles.
REQ-031 start held high with changing a/b during RUN -> the result reflects only the operands captured at acceptance; the next operation is accepted on the edge after DONE.
